// File: rtl/reg_alu_sequencer.sv
// rtl/reg_alu_sequencer.sv - multi-cycle register-register execute stage
// Reads B through the register file's shared read port and A from the R0 tap, then writes the result back to rd.
module reg_alu_sequencer #(
  parameter int WIDTH = 16,
  parameter int SELW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [SELW-1:0]  rd,
  input  logic [SELW-1:0]  rs,
  output logic             busy,
  output logic             done,
  output logic             flag_z,
  output logic             flag_c,
  output logic [SELW-1:0]  rf_sel_out,
  output logic             rf_output_enable,
  input  logic [WIDTH-1:0] rf_data_out,
  input  logic [WIDTH-1:0] rf_regA,
  output logic [SELW-1:0]  rf_sel_in,
  output logic [WIDTH-1:0] rf_data_in,
  output logic             rf_write_enable
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  state_t           state;
  logic [2:0]       op_q;
  logic [SELW-1:0]  rd_q;
  logic [SELW-1:0]  rs_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;

  logic [WIDTH:0]   alu_wide;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;

  // Strobes come straight from the state register so an async reset drops them at once.
  assign rf_output_enable = (state == READ);
  assign rf_write_enable  = (state == WRITE);
  assign rf_sel_out       = rs_q;
  assign rf_sel_in        = rd_q;
  assign rf_data_in       = result_q;

  always_comb begin
    alu_wide = '0;
    alu_res  = '0;
    alu_c    = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_wide = {1'b0, rf_regA} + {1'b0, b_q};
        alu_res  = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
      end
      OP_SUB, OP_CMP: begin
        // Top bit of the widened difference is the unsigned borrow.
        alu_wide = {1'b0, rf_regA} - {1'b0, b_q};
        alu_res  = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
      end
      OP_AND: alu_res = rf_regA & b_q;
      OP_OR:  alu_res = rf_regA | b_q;
      OP_XOR: alu_res = rf_regA ^ b_q;
      OP_MOV: alu_res = b_q;
      OP_SHL: begin
        alu_res = {rf_regA[WIDTH-2:0], 1'b0};
        alu_c   = rf_regA[WIDTH-1];
      end
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      op_q     <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= opcode;
            rd_q  <= rd;
            rs_q  <= rs;
            busy  <= 1'b1;
            state <= READ;
          end
        end
        READ: begin
          b_q   <= rf_data_out;
          state <= EXEC;
        end
        EXEC: begin
          result_q <= alu_res;
          flag_z   <= (alu_res == '0);
          flag_c   <= alu_c;
          if (op_q == OP_CMP) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            state <= WRITE;
          end
        end
        WRITE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// tb/tb_reg_alu_sequencer.sv - self-checking bench for reg_alu_sequencer
// Includes a behavioural 8x16 register file with a tri-stated read port and a preload path.
module tb_reg_alu_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  opcode;
  logic [2:0]  rd;
  logic [2:0]  rs;
  logic        busy;
  logic        done;
  logic        flag_z;
  logic        flag_c;
  logic [2:0]  rf_sel_out;
  logic        rf_output_enable;
  wire  [15:0] rf_data_out;
  logic [15:0] rf_regA;
  logic [2:0]  rf_sel_in;
  logic [15:0] rf_data_in;
  logic        rf_write_enable;

  logic [15:0] rf  [8];
  logic [15:0] mdl [8];
  logic        pre_we;
  logic [2:0]  pre_sel;
  logic [15:0] pre_data;
  int          wr_count;
  int          overlap_cnt;
  int          n_checks;
  int          n_fail;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [15:0] r0;
    logic [15:0] rsv;
    logic [15:0] res;
    logic        z;
    logic        c;
  } vec_t;

  vec_t tbl [12];

  reg_alu_sequencer #(.WIDTH(16), .SELW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .rd(rd), .rs(rs),
    .busy(busy), .done(done), .flag_z(flag_z), .flag_c(flag_c),
    .rf_sel_out(rf_sel_out), .rf_output_enable(rf_output_enable),
    .rf_data_out(rf_data_out), .rf_regA(rf_regA),
    .rf_sel_in(rf_sel_in), .rf_data_in(rf_data_in), .rf_write_enable(rf_write_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) rf[pre_sel] <= pre_data;
    else if (rf_write_enable) begin
      rf[rf_sel_in] <= rf_data_in;
      wr_count      <= wr_count + 1;
    end
  end

  always @(negedge clk)
    if (rf_output_enable && rf_write_enable) overlap_cnt <= overlap_cnt + 1;

  assign rf_data_out = rf_output_enable ? rf[rf_sel_out] : 16'hzzzz;
  assign rf_regA     = rf[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void ref_model(input int op, input int a, input int b,
                                    output logic [15:0] r, output logic z, output logic c);
    int s;
    c = 1'b0;
    case (op)
      0:       begin s = a + b; r = 16'(s % 65536); c = (s > 65535); end
      1, 7:    begin s = a - b + 65536; r = 16'(s % 65536); c = (a < b); end
      2:       r = 16'(a & b);
      3:       r = 16'(a | b);
      4:       r = 16'(a ^ b);
      5:       r = 16'(b);
      default: begin s = a * 2; r = 16'(s % 65536); c = (a >= 32768); end
    endcase
    z = (r == 16'h0000);
  endfunction

  task automatic preload(input logic [2:0] sel, input logic [15:0] data);
    pre_we = 1'b1; pre_sel = sel; pre_data = data;
    @(posedge clk); #1;
    pre_we = 1'b0;
    mdl[sel] = data;
  endtask

  // mode 1 keeps start asserted through cycles 1..3 to show it is ignored while busy.
  task automatic do_op(input logic [2:0] op, input logic [2:0] rd_i, input logic [2:0] rs_i,
                       input logic [15:0] exp_res, input logic exp_z, input logic exp_c,
                       input int mode, input string tag);
    int   wen_cyc, done_cyc, w0, mism;
    logic busy1, busy_done;
    bit   is_cmp;
    is_cmp = (op == 3'd7);
    w0 = wr_count;
    wen_cyc = -1; done_cyc = -1; busy1 = 1'b0; busy_done = 1'b1;
    start = 1'b1; opcode = op; rd = rd_i; rs = rs_i;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (rf_write_enable && wen_cyc < 0) wen_cyc = cyc;
      if (done && cyc > 0 && done_cyc < 0) begin done_cyc = cyc; busy_done = busy; end
      if (cyc == 1) busy1 = busy;
      @(posedge clk); #1;
      if (mode == 0 || cyc >= 3) start = 1'b0;
      if (cyc == 0) begin opcode = 3'd0; rd = 3'd7; rs = 3'd7; end
    end
    check({tag, " wen_cycle"}, wen_cyc, is_cmp ? -1 : 3);
    check({tag, " done_cycle"}, done_cyc, is_cmp ? 3 : 4);
    check({tag, " writes"}, wr_count - w0, is_cmp ? 0 : 1);
    check({tag, " busy_c1"}, busy1, 1);
    check({tag, " busy_at_done"}, busy_done, 0);
    check({tag, " flag_z"}, flag_z, exp_z);
    check({tag, " flag_c"}, flag_c, exp_c);
    if (!is_cmp) begin
      mdl[rd_i] = exp_res;
      check({tag, " rd_value"}, rf[rd_i], exp_res);
    end
    mism = 0;
    for (int i = 0; i < 8; i++) if (rf[i] !== mdl[i]) mism++;
    check({tag, " regfile"}, mism, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    int          w0, done_mask, wen_mask, mode;
    logic [2:0]  op, rdr, rsr;
    logic [15:0] er;
    logic        ez, ec;

    tbl[0]  = '{3'd0, 3'd2, 3'd3, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
    tbl[1]  = '{3'd1, 3'd4, 3'd1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b1};
    tbl[2]  = '{3'd2, 3'd1, 3'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0};
    tbl[3]  = '{3'd3, 3'd7, 3'd6, 16'h0F00, 16'h00F0, 16'h0FF0, 1'b0, 1'b0};
    tbl[4]  = '{3'd4, 3'd0, 3'd5, 16'h8001, 16'h00FF, 16'h80FE, 1'b0, 1'b0};
    tbl[5]  = '{3'd5, 3'd6, 3'd3, 16'h1234, 16'hABCD, 16'hABCD, 1'b0, 1'b0};
    tbl[6]  = '{3'd6, 3'd5, 3'd1, 16'h8001, 16'h1111, 16'h0002, 1'b0, 1'b1};
    tbl[7]  = '{3'd7, 3'd3, 3'd4, 16'h0007, 16'h0007, 16'h0000, 1'b1, 1'b0};
    tbl[8]  = '{3'd0, 3'd1, 3'd0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
    tbl[9]  = '{3'd1, 3'd2, 3'd0, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
    tbl[10] = '{3'd4, 3'd3, 3'd2, 16'h5555, 16'h5555, 16'h0000, 1'b1, 1'b0};
    tbl[11] = '{3'd6, 3'd4, 3'd4, 16'h4000, 16'h0000, 16'h8000, 1'b0, 1'b0};

    n_checks = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; opcode = '0; rd = '0; rs = '0;
    pre_we = 1'b0; pre_sel = '0; pre_data = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) preload(3'(i), 16'h0000);

    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset flags", {flag_z, flag_c}, 0);
    check("reset strobes", {rf_output_enable, rf_write_enable}, 0);
    check("reset sel/data", {rf_sel_out, rf_sel_in, rf_data_in}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      preload(3'd0, tbl[i].r0);
      if (tbl[i].rs != 3'd0) preload(tbl[i].rs, tbl[i].rsv);
      do_op(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].res, tbl[i].z, tbl[i].c, 0,
            $sformatf("vec%0d", i));
    end

    preload(3'd0, 16'h0005); preload(3'd1, 16'h0007);
    do_op(3'd1, 3'd4, 3'd1, 16'hFFFE, 1'b0, 1'b1, 0, "sub_borrow");
    do_op(3'd7, 3'd2, 3'd1, 16'h0000, 1'b0, 1'b1, 0, "cmp_after_sub");

    preload(3'd0, 16'h8001); preload(3'd5, 16'h00FF);
    do_op(3'd4, 3'd0, 3'd5, 16'h80FE, 1'b0, 1'b0, 0, "xor_r0");
    do_op(3'd6, 3'd0, 3'd5, 16'h01FC, 1'b0, 1'b1, 0, "shl_r0");
    do_op(3'd5, 3'd6, 3'd0, 16'h01FC, 1'b0, 1'b0, 0, "mov_from_r0");

    preload(3'd0, 16'h0100); preload(3'd3, 16'h0023);
    do_op(3'd0, 3'd5, 3'd3, 16'h0123, 1'b0, 1'b0, 1, "busy_ignore");

    // start held high: acceptance every 4 cycles, R1 accumulates R0 each time.
    preload(3'd0, 16'h0001); preload(3'd1, 16'h0001);
    w0 = wr_count; done_mask = 0; wen_mask = 0;
    start = 1'b1; opcode = 3'd0; rd = 3'd1; rs = 3'd1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      if (done) done_mask |= (1 << cyc);
      if (rf_write_enable) wen_mask |= (1 << cyc);
      @(posedge clk); #1;
      if (cyc == 8) start = 1'b0;
    end
    check("b2b done_mask", done_mask, 32'h1110);
    check("b2b wen_mask", wen_mask, 32'h0888);
    check("b2b writes", wr_count - w0, 3);
    check("b2b r1", rf[1], 16'h0004);
    mdl[1] = 16'h0004;

    // Async reset during WRITE aborts the write.
    preload(3'd0, 16'hF000); preload(3'd2, 16'h2000); preload(3'd7, 16'hAAAA);
    do_op(3'd7, 3'd0, 3'd0, 16'h0000, 1'b1, 1'b0, 0, "cmp_self");
    w0 = wr_count;
    start = 1'b1; opcode = 3'd0; rd = 3'd7; rs = 3'd2;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (cyc < 3) begin @(posedge clk); #1; start = 1'b0; end
    end
    check("rst pre wen", rf_write_enable, 1);
    check("rst pre flag_c", flag_c, 1);
    #1 rst = 1'b1;
    #1;
    check("rst wen drop", rf_write_enable, 0);
    check("rst oe", rf_output_enable, 0);
    check("rst busy/done", {busy, done}, 0);
    check("rst flags", {flag_z, flag_c}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst r7 kept", rf[7], 16'hAAAA);
    check("rst no write", wr_count - w0, 0);
    do_op(3'd0, 3'd7, 3'd2, 16'h1000, 1'b0, 1'b1, 0, "post_rst_add");

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) preload(3'($urandom_range(0, 7)), 16'($urandom));
      op  = 3'($urandom_range(0, 7));
      rdr = 3'($urandom_range(0, 7));
      rsr = 3'($urandom_range(0, 7));
      ref_model(int'(op), int'(mdl[0]), int'(mdl[rsr]), er, ez, ec);
      mode = (op != 3'd7 && $urandom_range(0, 3) == 0) ? 1 : 0;
      do_op(op, rdr, rsr, er, ez, ec, mode, $sformatf("rnd%0d", i));
    end

    check("strobe overlap", overlap_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_alu_sequencer.md
# reg_alu_sequencer

Multi-cycle execute stage that sits directly upstream of the 8×16-bit CPU register file and drives its ports. It accepts one register-register instruction (opcode, rd, rs). It then performs three steps:
- reads operand B from register `rs` through the file's single tri-stated read port;
- takes operand A from the always-visible `regA` (register 0) tap;
- computes the result and writes it back to `rd` through the file's write port.

It also maintains zero/carry flags for the downstream control logic.

## Interface
- `WIDTH`, 16, datapath width; must match the register file.
- `SELW`, 3, register-select width (8 registers).

- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  instruction valid; sampled only while `busy`=0.
- `opcode`  in  3  operation, captured with `start`.
- `rd`  in  SELW  destination register, captured with `start`.
- `rs`  in  SELW  source register, captured with `start`.
- `busy`  out  1  high from the cycle after acceptance until the op completes.
- `done`  out  1  one-cycle completion pulse.
- `flag_z`  out  1  last result == 0.
- `flag_c`  out  1  carry/borrow of the last op.
- `rf_sel_out`  out  SELW  to register-file read select.
- `rf_output_enable`  out  1  to register-file read enable.
- `rf_data_out`  in  WIDTH  from register-file read port (high-Z when not enabled).
- `rf_regA`  in  WIDTH  from register-file register-0 tap.
- `rf_sel_in`  out  SELW  to register-file write select.
- `rf_data_in`  out  WIDTH  to register-file write data.
- `rf_write_enable`  out  1  to register-file write enable.

## Operation

**FSM states:** IDLE, READ, EXEC, WRITE.

- **IDLE**
  - `start`=1: latch `opcode`/`rd`/`rs` into `op_q`/`rd_q`/`rs_q`, then go to READ.
  - Otherwise stay in IDLE.
- **READ**
  - Drive `rf_output_enable`=1.
  - Capture `rf_data_out` into `b_q` at the clock edge, then go to EXEC.
- **EXEC**
  - Compute from A=`rf_regA` (sampled this cycle) and B=`b_q`.
  - Register `result_q`, `flag_z` and `flag_c`.
  - Go to WRITE, except CMP, which goes to IDLE with `done`=1.
- **WRITE**
  - Drive `rf_write_enable`=1 for exactly one cycle.
  - Go to IDLE with `done`=1.

**Fixed port assignments (all states):**
- `rf_sel_out`=`rs_q`
- `rf_sel_in`=`rd_q`
- `rf_data_in`=`result_q`

**Opcodes.** Arithmetic is modulo 2^WIDTH. Carry is computed over WIDTH+1 bits.
- 0 ADD: A+B; C = carry out.
- 1 SUB: A−B; C = borrow (A<B, unsigned).
- 2 AND, 3 OR, 4 XOR: bitwise; C=0.
- 5 MOV: B; C=0.
- 6 SHL: A<<1; C=A[WIDTH−1]; B is still read but unused.
- 7 CMP: A−B; flags as SUB; no write-back.

**Flags:**
- `flag_z` = (result == 0).
- Flags update only in EXEC and hold otherwise.

**Boundary cases:**
- `start` while busy: ignored, never queued.
- `rs`=0: reads register 0 through the port, so B equals A.
- `rd`=0: writes register 0, so the new `rf_regA` is visible on the next instruction.
- Back-to-back: `start` in the same cycle as `done` (state IDLE) is accepted.

**Reset (async, any state):**
- Effect: state→IDLE; `busy`, `done`, `flags`, `op_q`, `rd_q`, `rs_q`, `b_q` and `result_q` all →0.
- `rf_output_enable` and `rf_write_enable` →0 immediately, without waiting for a clock edge. An in-flight instruction is aborted and no write occurs.

## Timing
- Cycle 0: `start` high in IDLE.
- Cycle 1: READ, `busy`=1, `rf_output_enable`=1.
- Cycle 2: EXEC.
- Cycle 3: WRITE, `rf_write_enable`=1; the register file updates at the end of cycle 3.
- Cycle 4: IDLE, `done`=1, `busy`=0; new `start` accepted.
- CMP: `done` in cycle 3, no write; total 3 cycles.
- Throughput: one instruction per 4 cycles (3 for CMP).
- `rf_output_enable` and `rf_write_enable` are decoded from the registered state only and are never high in the same cycle.
- `busy`, `done` and the flags are registered outputs.

## Test plan
- **ADD carry:** reset, preload R0=0xFFFF, R3=0x0001; issue ADD rd=2 rs=3 → R2=0x0000, `flag_z`=1, `flag_c`=1; `rf_write_enable` high only in cycle 3; `done` in cycle 4.
- **SUB borrow then CMP:** R0=0x0005, R1=0x0007; SUB rd=4 rs=1 → R4=0xFFFE, C=1, Z=0. Then CMP rs=1 → no write strobe, `done` 3 cycles after `start`, R0 unchanged.
- **Logic/MOV/SHL with rd=0:** R0=0x8001, R5=0x00FF; XOR rd=0 rs=5 → R0=0x80FE. Then SHL rd=0 → R0=0x01FC, C=1. Then MOV rd=6 rs=0 → R6=0x01FC.
- **Busy/back-to-back:**
  - Pulse `start` in cycles 1–3 of an op → ignored; exactly one write.
  - Hold `start` continuously → instructions accepted every 4 cycles, with `done` and acceptance coinciding.
- **Async reset mid-op:** assert `rst` between edges during WRITE → `rf_write_enable` drops immediately; destination retains its old value; `busy`, `done` and `flags`=0; next instruction executes normally.
